// File: rtl/binsearch_engine_if.sv
// Request/result handshake and synchronous-read memory bus of binsearch_engine.
interface binsearch_engine_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
);
  logic              start;
  logic              mode;
  logic [DATA_W-1:0] target;
  logic              busy;
  logic              done;
  logic              found;
  logic [ADDR_W-1:0] f_addr;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output start, mode, target, mem_rdata,
    input  busy, done, found, f_addr, mem_rd, mem_addr
  );

  modport slave (
    input  start, mode, target, mem_rdata,
    output busy, done, found, f_addr, mem_rd, mem_addr
  );
endinterface

// File: rtl/binsearch_engine.sv
// Binary search (exact / lower-bound) over an external sorted 1-cycle-latency RAM.
// Optional BSEARCH_PROBE_COUNT_EN adds a probe_cnt output counting probes per search.
module binsearch_engine #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic clock,
  input  logic reset,
  binsearch_engine_if.slave bus
`ifdef BSEARCH_PROBE_COUNT_EN
  ,
  output logic [$clog2(ADDR_W+2)-1:0] probe_cnt
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_PROBE, S_CMP, S_DONE} state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] l, l_n, r, r_n, m, m_n, cand, cand_n;
  logic              cv, cv_n, md, md_n, found, found_n;
  logic [ADDR_W-1:0] faddr, faddr_n;
  logic [DATA_W-1:0] tgt, tgt_n;
  logic [ADDR_W-1:0] mid;
  logic              hit, above, term;

  // Midpoint sum is formed one bit wider so L+R cannot wrap.
  assign mid = ADDR_W'(({1'b0, l} + {1'b0, r}) >> 1);

  assign bus.mem_rd   = (state == S_PROBE);
  assign bus.mem_addr = (state == S_PROBE) ? mid : m;
  assign bus.busy     = (state == S_PROBE) || (state == S_CMP);
  assign bus.done     = (state == S_DONE);
  assign bus.found    = found;
  assign bus.f_addr   = faddr;

`ifdef BSEARCH_PROBE_COUNT_EN
  localparam int PCW = $clog2(ADDR_W+2);
  logic [PCW-1:0] pc, pc_n;
  assign probe_cnt = pc;
`endif

  always_comb begin
    state_n = state;
    l_n     = l;
    r_n     = r;
    m_n     = m;
    cand_n  = cand;
    cv_n    = cv;
    md_n    = md;
    tgt_n   = tgt;
    found_n = found;
    faddr_n = faddr;
`ifdef BSEARCH_PROBE_COUNT_EN
    pc_n    = pc;
`endif
    hit     = (bus.mem_rdata == tgt);
    above   = (bus.mem_rdata > tgt);
    term    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (bus.start) begin
          tgt_n   = bus.target;
          md_n    = bus.mode;
          l_n     = '0;
          r_n     = '1;
          cand_n  = '0;
          cv_n    = 1'b0;
          found_n = 1'b0;
          faddr_n = '0;
`ifdef BSEARCH_PROBE_COUNT_EN
          pc_n    = '0;
`endif
          state_n = S_PROBE;
        end
      end
      S_PROBE: begin
        m_n     = mid;
`ifdef BSEARCH_PROBE_COUNT_EN
        pc_n    = pc + PCW'(1);
`endif
        state_n = S_CMP;
      end
      S_CMP: begin
        if (hit && !md) begin
          found_n = 1'b1;
          faddr_n = m;
          state_n = S_DONE;
        end else begin
          if (md && (hit || above)) begin
            cand_n = m;
            cv_n   = 1'b1;
          end
          // L > M-1 is tested as L >= M, and M+1 > R as M >= R, avoiding wrap.
          if (hit || above) begin
            if (m == '0 || l >= m) term = 1'b1;
            else begin
              r_n     = m - ADDR_W'(1);
              state_n = S_PROBE;
            end
          end else begin
            if (m == '1 || m >= r) term = 1'b1;
            else begin
              l_n     = m + ADDR_W'(1);
              state_n = S_PROBE;
            end
          end
          if (term) begin
            found_n = md && cv_n;
            faddr_n = (md && cv_n) ? cand_n : '0;
            state_n = S_DONE;
          end
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      l     <= '0;
      r     <= '0;
      m     <= '0;
      cand  <= '0;
      cv    <= 1'b0;
      md    <= 1'b0;
      tgt   <= '0;
      found <= 1'b0;
      faddr <= '0;
`ifdef BSEARCH_PROBE_COUNT_EN
      pc    <= '0;
`endif
    end else begin
      state <= state_n;
      l     <= l_n;
      r     <= r_n;
      m     <= m_n;
      cand  <= cand_n;
      cv    <= cv_n;
      md    <= md_n;
      tgt   <= tgt_n;
      found <= found_n;
      faddr <= faddr_n;
`ifdef BSEARCH_PROBE_COUNT_EN
      pc    <= pc_n;
`endif
    end
  end

endmodule

// File: tb/tb_binsearch_engine.sv
// Directed self-checking bench for binsearch_engine; memory holds mem[i] = 2i+1.
module tb_binsearch_engine;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 5;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  binsearch_engine_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

`ifdef BSEARCH_PROBE_COUNT_EN
  logic [$clog2(ADDR_W+2)-1:0] probe_cnt;
`endif

  binsearch_engine #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
`ifdef BSEARCH_PROBE_COUNT_EN
    ,
    .probe_cnt (probe_cnt)
`endif
  );

  always @(posedge clock)
    if (bus.mem_rd) bus.mem_rdata <= DATA_W'({bus.mem_addr, 1'b1});

  int n_cmp = 0;
  int n_err = 0;
  int probe_q[$];
  int r_cycles;
  bit r_busy_bad;
  bit r_timeout;

  // Launch a search and wait (bounded) for done; leaves caller at done-cycle negedge.
  task automatic run_search(input logic [DATA_W-1:0] t, input logic md, input bit at_negedge);
    if (!at_negedge) @(negedge clock);
    bus.target = t;
    bus.mode   = md;
    bus.start  = 1'b1;
    probe_q.delete();
    r_cycles   = 0;
    r_busy_bad = 1'b0;
    r_timeout  = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (c > 1) @(negedge clock);
      if (bus.mem_rd) probe_q.push_back(int'(bus.mem_addr));
      if (bus.done) begin
        r_cycles  = c;
        r_timeout = 1'b0;
        if (bus.busy) r_busy_bad = 1'b1;
        break;
      end
      if (!bus.busy) r_busy_bad = 1'b1;
    end
  endtask

  task automatic test_reset();
    bus.start  = 1'b0;
    bus.mode   = 1'b0;
    bus.target = '0;
    reset      = 1'b0;
    repeat (2) @(negedge clock);
    n_cmp++;
    if ({bus.busy, bus.done, bus.found, bus.f_addr, bus.mem_rd, bus.mem_addr} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got busy=%b done=%b found=%b f_addr=%0d mem_rd=%b mem_addr=%0d expected all 0",
               bus.busy, bus.done, bus.found, bus.f_addr, bus.mem_rd, bus.mem_addr);
    end
    reset = 1'b1;
  endtask

  task automatic test_exact_hit();
    int  exp_p[5] = '{15, 23, 19, 17, 16};
    bit  seq_ok;
    run_search(8'd33, 1'b0, 1'b0);
    n_cmp++;
    if (r_cycles !== 11) begin
      n_err++; $display("FAIL hit_latency: got %0d expected 11", r_cycles);
    end
    n_cmp++;
    if (r_busy_bad !== 1'b0) begin
      n_err++; $display("FAIL hit_busy_window: got bad=%b expected 0", r_busy_bad);
    end
    seq_ok = (probe_q.size() == 5);
    if (seq_ok) for (int i = 0; i < 5; i++) if (probe_q[i] != exp_p[i]) seq_ok = 1'b0;
    n_cmp++;
    if (!seq_ok) begin
      n_err++; $display("FAIL hit_probe_seq: got %0d probes (first %0d) expected 15,23,19,17,16",
                        probe_q.size(), (probe_q.size() > 0) ? probe_q[0] : -1);
    end
    n_cmp++;
    if ({bus.found, bus.f_addr} !== {1'b1, 5'd16}) begin
      n_err++; $display("FAIL hit_result: got found=%b f_addr=%0d expected 1/16", bus.found, bus.f_addr);
    end
`ifdef BSEARCH_PROBE_COUNT_EN
    n_cmp++;
    if (probe_cnt !== 3'd5) begin
      n_err++; $display("FAIL hit_probe_cnt: got %0d expected 5", probe_cnt);
    end
`endif
    @(negedge clock);
    n_cmp++;
    if ({bus.done, bus.found, bus.f_addr} !== {1'b0, 1'b1, 5'd16}) begin
      n_err++; $display("FAIL hit_hold: got done=%b found=%b f_addr=%0d expected 0/1/16",
                        bus.done, bus.found, bus.f_addr);
    end
  endtask

  task automatic test_lower_bound();
    run_search(8'd34, 1'b0, 1'b0);
    n_cmp++;
    if ({r_timeout, bus.found, bus.f_addr} !== {1'b0, 1'b0, 5'd0}) begin
      n_err++; $display("FAIL exact_miss: got to=%b found=%b f_addr=%0d expected 0/0/0",
                        r_timeout, bus.found, bus.f_addr);
    end
    run_search(8'd34, 1'b1, 1'b0);
    n_cmp++;
    if ({r_timeout, bus.found, bus.f_addr} !== {1'b0, 1'b1, 5'd17}) begin
      n_err++; $display("FAIL lower_bound_34: got to=%b found=%b f_addr=%0d expected 0/1/17",
                        r_timeout, bus.found, bus.f_addr);
    end
  endtask

  task automatic test_boundaries();
    run_search(8'd0, 1'b1, 1'b0);
    n_cmp++;
    if ({r_timeout, bus.found, bus.f_addr} !== {1'b0, 1'b1, 5'd0}) begin
      n_err++; $display("FAIL lb_zero: got to=%b found=%b f_addr=%0d expected 0/1/0",
                        r_timeout, bus.found, bus.f_addr);
    end
    run_search(8'd0, 1'b0, 1'b0);
    n_cmp++;
    if ({r_timeout, bus.found, bus.f_addr} !== {1'b0, 1'b0, 5'd0}) begin
      n_err++; $display("FAIL exact_zero: got to=%b found=%b f_addr=%0d expected 0/0/0",
                        r_timeout, bus.found, bus.f_addr);
    end
    n_cmp++;
    if (probe_q.size() != 5 || probe_q[probe_q.size()-1] != 0) begin
      n_err++; $display("FAIL exact_zero_probes: got %0d probes expected 5 ending at 0", probe_q.size());
    end
    run_search(8'd63, 1'b0, 1'b0);
    n_cmp++;
    if ({r_timeout, bus.found, bus.f_addr} !== {1'b0, 1'b1, 5'd31}) begin
      n_err++; $display("FAIL exact_63: got to=%b found=%b f_addr=%0d expected 0/1/31",
                        r_timeout, bus.found, bus.f_addr);
    end
    n_cmp++;
    if (r_cycles !== 13) begin
      n_err++; $display("FAIL exact_63_latency: got %0d expected 13", r_cycles);
    end
`ifdef BSEARCH_PROBE_COUNT_EN
    n_cmp++;
    if (probe_cnt !== 3'd6) begin
      n_err++; $display("FAIL exact_63_probe_cnt: got %0d expected 6", probe_cnt);
    end
`endif
    run_search(8'd64, 1'b1, 1'b0);
    n_cmp++;
    if ({r_timeout, bus.found, bus.f_addr} !== {1'b0, 1'b0, 5'd0}) begin
      n_err++; $display("FAIL lb_64: got to=%b found=%b f_addr=%0d expected 0/0/0",
                        r_timeout, bus.found, bus.f_addr);
    end
  endtask

  task automatic test_back_to_back();
    int dones = 0;
    int done_c = 0;
    bit busy_at4 = 1'b0;
    @(negedge clock);
    bus.target = 8'd33;
    bus.mode   = 1'b0;
    bus.start  = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (c > 1) @(negedge clock);
      if (c == 3) begin bus.start = 1'b1; bus.target = 8'd1; end
      if (c == 4) begin bus.start = 1'b0; busy_at4 = bus.busy; end
      if (bus.done) begin dones++; done_c = c; break; end
    end
    n_cmp++;
    if ({done_c, busy_at4, bus.found, bus.f_addr} !== {32'd11, 1'b1, 1'b1, 5'd16}) begin
      n_err++; $display("FAIL ignore_start: got done_cycle=%0d busy4=%b found=%b f_addr=%0d expected 11/1/1/16",
                        done_c, busy_at4, bus.found, bus.f_addr);
    end
    @(negedge clock);
    if (bus.done) dones++;
    n_cmp++;
    if (dones !== 1) begin
      n_err++; $display("FAIL single_done: got %0d pulses expected 1", dones);
    end
    run_search(8'd5, 1'b0, 1'b1);
    n_cmp++;
    if ({r_cycles, bus.found, bus.f_addr} !== {32'd11, 1'b1, 5'd2}) begin
      n_err++; $display("FAIL back_to_back: got cycles=%0d found=%b f_addr=%0d expected 11/1/2",
                        r_cycles, bus.found, bus.f_addr);
    end
  endtask

  task automatic test_reset_mid();
    int dones = 0;
    run_search(8'd33, 1'b0, 1'b0);
    @(negedge clock);
    bus.target = 8'd33;
    bus.mode   = 1'b0;
    bus.start  = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    repeat (4) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    n_cmp++;
    if ({bus.busy, bus.done, bus.found, bus.f_addr, bus.mem_rd} !== '0) begin
      n_err++; $display("FAIL mid_reset: got busy=%b done=%b found=%b f_addr=%0d mem_rd=%b expected all 0",
                        bus.busy, bus.done, bus.found, bus.f_addr, bus.mem_rd);
    end
`ifdef BSEARCH_PROBE_COUNT_EN
    n_cmp++;
    if (probe_cnt !== '0) begin
      n_err++; $display("FAIL mid_reset_probe_cnt: got %0d expected 0", probe_cnt);
    end
`endif
    reset = 1'b1;
    for (int c = 0; c < 15; c++) begin
      @(negedge clock);
      if (bus.done) dones++;
    end
    n_cmp++;
    if (dones !== 0) begin
      n_err++; $display("FAIL mid_reset_no_done: got %0d pulses expected 0", dones);
    end
    run_search(8'd5, 1'b0, 1'b0);
    n_cmp++;
    if ({r_timeout, bus.found, bus.f_addr} !== {1'b0, 1'b1, 5'd2}) begin
      n_err++; $display("FAIL after_reset_search: got to=%b found=%b f_addr=%0d expected 0/1/2",
                        r_timeout, bus.found, bus.f_addr);
    end
  endtask

  initial begin
    test_reset();
    test_exact_hit();
    test_lower_bound();
    test_boundaries();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/binsearch_engine.md
Name: binsearch_engine

Overview:
- Parametrised binary-search engine over an external sorted (ascending, unsigned) synchronous-read memory of 2**ADDR_W words.
- Supports exact-match and lower-bound modes, a start/done handshake, and correct handling of both array ends.
- Sits between the search-request logic and the RAM.
- Successor to the fixed 8-bit/32-entry controller/datapath search pair.

Parameters:
- DATA_W, 8, width of memory words and target.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries.

Ports:
- clock  input  1  system clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- mode  input  1  0 = exact match, 1 = lower bound (first index with mem >= target); latched on start.
- target  input  DATA_W  search key; latched on start.
- mem_rd  output  1  read strobe, high only in PROBE.
- mem_addr  output  ADDR_W  probe address M.
- mem_rdata  input  DATA_W  read data, valid the cycle after mem_rd (1-cycle latency).
- busy  output  1  high from the cycle after start is accepted until DONE.
- done  output  1  one-cycle completion pulse.
- found  output  1  result flag; held until the next accepted start.
- f_addr  output  ADDR_W  result index; held until the next accepted start; 0 when found=0.

Behaviour:
- Reset (reset=0, async):
  - State IDLE.
  - busy, done, found, f_addr, mem_rd, mem_addr all 0.
  - Internal L, R, M, candidate, target and mode registers cleared.
  - Reset asserted mid-search aborts the search; no done pulse is generated.
- States: IDLE, PROBE, CMP, DONE.
- IDLE:
  - On start=1: latch target and mode, L=0, R=DEPTH-1, cand_valid=0, clear found/f_addr, go to PROBE.
  - start=0: stay in IDLE.
- PROBE:
  - M = (L+R)>>1, computed in ADDR_W+1 bits (no overflow).
  - mem_addr=M, mem_rd=1; go to CMP.
- CMP (mem_rdata valid):
  - rdata == target:
    - mode 0: found=1, f_addr=M, go to DONE.
    - mode 1: cand=M, cand_valid=1, go left.
  - rdata > target: mode 1 also sets cand=M, cand_valid=1; go left.
  - rdata < target: go right.
  - Go left: if M==0 or L>M-1, terminate; else R=M-1, go to PROBE.
  - Go right: if M==DEPTH-1 or M+1>R, terminate; else L=M+1, go to PROBE.
  - Terminate (no exact hit): mode 0 gives found=0. Mode 1 gives found=cand_valid, f_addr=cand (or 0). Then go to DONE.
- DONE:
  - done=1 for exactly one cycle; busy=0 in this cycle.
  - Return to IDLE; found/f_addr remain stable.
- Timing:
  - Each probe costs 2 cycles.
  - With k probes, done is high in the (2k+1)th cycle after the start-sampling edge.
  - k <= ADDR_W+1.
- start while busy or in DONE is ignored (not queued).
- No combinational path from inputs to outputs except none; all outputs are registered or decoded from state.

Optional Feature:
- Macro: BSEARCH_PROBE_COUNT_EN.
- Defined:
  - Adds output probe_cnt [$clog2(ADDR_W+2)-1:0].
  - Counts PROBE states of the current search; cleared on accepted start and on reset.
  - Holds its final value with found/f_addr.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
Common setup: DATA_W=8, ADDR_W=5, mem[i]=2i+1 (1..63).
1. Exact hit: mode=0, target=33 -> probes M=15,23,19,17,16; done 11 cycles after start edge; found=1, f_addr=16; busy high cycles 1-10.
2. Exact miss vs lower bound: target=34, mode=0 -> found=0, f_addr=0. Same target, mode=1 -> found=1, f_addr=17.
3. Boundaries:
   - target=0, mode=1 -> found=1, f_addr=0.
   - target=0, mode=0 -> found=0, with no M-1 underflow (no stray probe).
   - target=63, mode=0 -> found=1, f_addr=31.
   - target=64, mode=1 -> found=0.
4. Handshake: start pulsed during busy (target=1) -> ignored; original search (target=33) completes with f_addr=16; exactly one done pulse. Back-to-back start in the cycle after done is accepted.
5. Reset mid-search: reset low for 1 cycle at cycle 5 -> busy=0, done never pulses, found=0, f_addr=0. Next start with target=5 -> found=1, f_addr=2.
6. BSEARCH_PROBE_COUNT_EN defined: scenario 1 -> probe_cnt=5. target=63 -> probe_cnt=6 (M=15,23,27,29,30,31). Without the macro, the bench compiles with no probe_cnt port.
